// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline definitions.
//   mult_state_t : multiplier FSM states (IDLE, RUN, DONE)
//   MULT_WIDTH   : default datapath width of the multiply unit
//   FUNCT_*      : R-type funct codes decoded for multiply and HI/LO moves
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH = 32;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/ex_mult_unit.sv
// ex_mult_unit: sequential shift-add multiplier for the EX stage.
// It owns the architectural HI/LO registers and needs WIDTH cycles per product.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, is_signed  issue MULT (is_signed=1) or MULTU (is_signed=0)
//   mul_clr           abort any multiply in flight and clear HI/LO
//   op_a, op_b        rs / rt operand values
//   hi_we, lo_we      MTHI / MTLO write strobes, with wdata as the data
//   hi, lo            architectural HI/LO
//   busy              high while the multiply is iterating
//   done              one-cycle pulse after HI/LO receive a new product
//   stall             stall request to the hazard unit
//
// Build option: define MULT_SIGNED_EN to honour is_signed. This builds the
// operand magnitude conversion and the final negation. When the macro is not
// defined, every multiply is unsigned and is_signed is ignored.
module ex_mult_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             mul_clr,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t          state_reg, state_next;
    logic [CW-1:0]        count_reg;
    logic [WIDTH-1:0]     mcand_reg;    // multiplicand magnitude
    logic [WIDTH-1:0]     mplier_reg;   // multiplier; low product bits shift in from the top
    logic [WIDTH-1:0]     upper_reg;    // upper half of the partial product
    logic                 neg_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;

    logic                 last_step;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     upper_shift;
    logic [WIDTH-1:0]     mplier_shift;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 neg_in;

    // Convert the operands to magnitudes when the multiply is issued. The most
    // negative value maps to 2^(WIDTH-1). That value still fits WIDTH bits
    // when the bits are read as unsigned.
`ifdef MULT_SIGNED_EN
    always_comb begin
        mag_a  = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
        mag_b  = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
        neg_in = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    always_comb begin
        mag_a  = op_a;
        mag_b  = op_b;
        neg_in = 1'b0;
    end
`endif

    // One shift-add step. The carry of the add becomes the new top bit of
    // {upper, multiplier} after the right shift.
    always_comb begin
        sum          = {1'b0, upper_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        upper_shift  = sum[WIDTH:1];
        mplier_shift = {sum[0], mplier_reg[WIDTH-1:1]};
        product      = {upper_shift, mplier_shift};
`ifdef MULT_SIGNED_EN
        result       = neg_reg ? (~product + 1'b1) : product;
`else
        result       = product;
`endif
    end

    assign last_step = (count_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
        if (mul_clr) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            upper_reg  <= '0;
            neg_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else if (mul_clr) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            upper_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RUN) begin
                upper_reg  <= upper_shift;
                mplier_reg <= mplier_shift;
                count_reg  <= count_reg + 1'b1;
                // count wraps back to zero on the last step and is ready for the next multiply.
                if (last_step) begin
                    hi_reg <= result[2*WIDTH-1:WIDTH];
                    lo_reg <= result[WIDTH-1:0];
                end
            end else begin
                // A start in the same cycle also lets the write land.
                // The later commit overwrites it.
                if (hi_we) hi_reg <= wdata;
                if (lo_we) lo_reg <= wdata;
                if (start) begin
                    mcand_reg  <= mag_a;
                    mplier_reg <= mag_b;
                    neg_reg    <= neg_in;
                    upper_reg  <= '0;
                    count_reg  <= '0;
                end
            end
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign stall = busy | (start & (state_reg != RUN));

endmodule

// File: tb/tb_ex_mult_unit.sv
module tb_ex_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         mul_clr = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall;

    ex_mult_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .mul_clr(mul_clr), .op_a(op_a), .op_b(op_b), .hi_we(hi_we),
        .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference product, computed directly from the operand values.
    function automatic logic [2*W-1:0] ref_prod(logic [W-1:0] a, logic [W-1:0] b, bit s);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`ifdef MULT_SIGNED_EN
        if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
`else
        if (s) p = p;
`endif
        return p;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok %s = %h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: a done pulse must match the oldest queued product and its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Call at a negedge. Start is sampled at the following posedge.
    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, bit s, bit push);
        exp_t           e;
        logic [2*W-1:0] p;
        op_a = a;
        op_b = b;
        is_signed = s;
        start = 1'b1;
        if (push) begin
            p = ref_prod(a, b, s);
            e.hi = p[2*W-1:W];
            e.lo = p[W-1:0];
            e.cyc = cyc + 1 + W;
            sb.push_back(e);
        end
        #1 check("stall_on_start", {63'b0, stall}, 64'd1);
        $display("[TB] issue a=%h b=%h signed=%0d push=%0d", a, b, s, push);
    endtask

    // Returns at the negedge where done is high, or after the cycle budget runs out.
    // At iteration inject_at, this task drives a stray start and an MTHI write during RUN.
    task automatic wait_done(int inject_at);
        bit seen = 0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check("stall_in_done", {63'b0, stall}, 64'd0);
            end else begin
                check("busy_stall_run", {62'b0, busy, stall}, 64'd3);
            end
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            if (i == inject_at) begin
                start = 1'b1;
                op_a  = $urandom;
                op_b  = $urandom;
                hi_we = 1'b1;
                wdata = $urandom;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", W + 4);
        end
    endtask

    initial begin
        logic [W-1:0] x;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_flags", {61'b0, busy, done, stall}, 0);
        reset = 1'b0;

        // 7 x 9, then the done pulse must last one cycle
        @(negedge clk);
        issue(32'd7, 32'd9, 0, 1);
        wait_done(-1);
        @(negedge clk);
        check("done_one_cycle", {63'b0, done}, 0);

        // All-ones unsigned, then -3 x 5 as MULT
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        wait_done(-1);
        issue(32'hFFFF_FFFD, 32'd5, 1, 1);
        wait_done(-1);
        issue(32'h8000_0000, 32'h8000_0000, 1, 1);
        wait_done(-1);

        // MTHI/MTLO in IDLE, then mul_clr at RUN cycle 10
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_idle", hi, 32'hA5A5_1234);
        check("mtlo_idle", lo, 32'hA5A5_1234);
        issue(32'd11, 32'd13, 0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        mul_clr = 1'b1;
        @(negedge clk);
        mul_clr = 1'b0;
        check("clr_busy", {63'b0, busy}, 0);
        check("clr_hi", hi, 0);
        check("clr_lo", lo, 0);
        repeat (W + 4) @(negedge clk);
        // A start in the same cycle as mul_clr is dropped.
        start = 1'b1; mul_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; mul_clr = 1'b0;
        check("clr_drops_start", {63'b0, busy}, 0);

        // Write and start in the same cycle: the write is visible while RUN is active.
        hi_we = 1'b1; wdata = 32'h1357_9BDF;
        issue(32'd100, 32'd200, 0, 1);
        wait_done(-1);
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        issue(32'd3, 32'd4, 0, 1);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("write_with_start", hi, 32'h0BAD_F00D);
        wait_done(-1);

        // Stray start plus MTHI during RUN are ignored, and the next multiply is issued back-to-back in DONE.
        @(negedge clk);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 0, 1);
        wait_done(5);
        issue(32'hDEAD_BEEF, 32'h0000_0033, 0, 1);
        wait_done(-1);

        // Reset while RUN is active, then 2 x 3
        issue(32'h0FFF_FFFF, 32'h0FFF_FFFF, 0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_flags", {61'b0, busy, done, stall}, 0);
        issue(32'd2, 32'd3, 0, 1);
        wait_done(-1);

        // Random multiplies, some issued back-to-back
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 3))
                0: x = 32'h8000_0000;
                1: x = 32'hFFFF_FFFF;
                default: x = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            issue(x, $urandom, 1'($urandom_range(0, 1)), 1);
            wait_done(-1);
        end

        repeat (4) @(negedge clk);
        start = 1'b0;
        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
